// File: rtl/sync_fifo_wc_if.sv
// Handshake/data bundle for sync_fifo_wc.
//   master : producer/consumer side (drives wr_en, din, rd_en; observes status)
//   slave  : FIFO side (drives dout, full/empty, threshold and sticky flags, fifo_cnt)
// W_WIDTH/R_WIDTH/DEPTH must match the parameters of the attached FIFO.
interface sync_fifo_wc_if #(
    parameter int W_WIDTH = 32,
    parameter int R_WIDTH = 8,
    parameter int DEPTH   = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic               wr_en;
    logic [W_WIDTH-1:0] din;
    logic               rd_en;
    logic [R_WIDTH-1:0] dout;
    logic               wfull;
    logic               rempty;
    logic               almost_full;
    logic               almost_empty;
    logic               overflow;
    logic               underflow;
    logic [CW-1:0]      fifo_cnt;

    modport master (
        output wr_en, din, rd_en,
        input  dout, wfull, rempty, almost_full, almost_empty, overflow, underflow, fifo_cnt
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, wfull, rempty, almost_full, almost_empty, overflow, underflow, fifo_cnt
    );
endinterface

// File: rtl/sync_fifo_wc.sv
// Single-clock FIFO with integer-ratio width conversion (pack W<R, unpack W>R,
// or equal width), arbitrary DEPTH >= 2, selectable sub-word order,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    sync_fifo_wc_if.slave: wr_en/din in, rd_en in, dout (registered),
//          wfull, rempty, almost_full, almost_empty, overflow, underflow, fifo_cnt
module sync_fifo_wc #(
    parameter int W_WIDTH   = 32,
    parameter int R_WIDTH   = 8,
    parameter int DEPTH     = 16,
    parameter int LSB_FIRST = 1,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_wc_if.slave   bus
);
    localparam int MAXW   = (W_WIDTH > R_WIDTH) ? W_WIDTH : R_WIDTH;
    localparam int MINW   = (W_WIDTH > R_WIDTH) ? R_WIDTH : W_WIDTH;
    localparam int RATIO  = MAXW / MINW;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int PW     = $clog2(DEPTH);
    localparam int SW     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam bit PACK   = (W_WIDTH < R_WIDTH);
    localparam bit UNPACK = (W_WIDTH > R_WIDTH);

    generate
        if ((MAXW % MINW) != 0) begin : g_bad_ratio
            $error("sync_fifo_wc: max(W_WIDTH,R_WIDTH) must be a multiple of min(W_WIDTH,R_WIDTH)");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_wc: DEPTH must be >= 2");
        end
    endgenerate

    logic [MAXW-1:0]    mem_q [DEPTH];

    logic [PW-1:0]      w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [SW-1:0]      w_sub_q, w_sub_d, r_sub_q, r_sub_d;
    logic [MAXW-1:0]    pack_q, pack_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [R_WIDTH-1:0] dout_q, dout_d;
    logic               overflow_q, overflow_d, underflow_q, underflow_d;

    logic               wfull, rempty, wr_ok, rd_ok, ent_we, ent_fr;
    logic               w_last, r_last;
    logic [SW-1:0]      w_slot, r_slot;
    logic [MAXW-1:0]    wr_word, rd_word;

    // Status is decoded from the registered count only, so a same-cycle
    // free never opens room for a write and a same-cycle write never
    // makes data readable.
    assign wfull  = (cnt_q == CW'(DEPTH));
    assign rempty = (cnt_q == '0);
    assign wr_ok  = bus.wr_en & ~wfull;
    assign rd_ok  = bus.rd_en & ~rempty;

    assign w_last = (w_sub_q == SW'(RATIO - 1));
    assign r_last = (r_sub_q == SW'(RATIO - 1));

    // Slot of the current narrow beat inside the wide word.
    assign w_slot = (LSB_FIRST != 0) ? w_sub_q : SW'(RATIO - 1) - w_sub_q;
    assign r_slot = (LSB_FIRST != 0) ? r_sub_q : SW'(RATIO - 1) - r_sub_q;

    // An entry is written on every accepted beat, except in pack mode
    // where only the last beat completes a word.
    assign ent_we = wr_ok & (~PACK   | w_last);
    // In unpack mode the entry stays occupied until its last slice is read.
    assign ent_fr = rd_ok & (~UNPACK | r_last);

    assign rd_word = mem_q[r_ptr_q];

    always_comb begin
        // Pack register with the incoming beat merged in; on the final beat
        // this is the complete word written to memory.
        wr_word = pack_q;
        wr_word[w_slot*MINW +: MINW] = bus.din[MINW-1:0];
        if (!PACK) begin
            wr_word = MAXW'(bus.din);
        end

        pack_d  = pack_q;
        w_sub_d = w_sub_q;
        if (wr_ok && PACK) begin
            if (w_last) begin
                w_sub_d = '0;
            end else begin
                w_sub_d = w_sub_q + 1'b1;
                pack_d  = wr_word;
            end
        end

        dout_d  = dout_q;
        r_sub_d = r_sub_q;
        if (rd_ok) begin
            if (UNPACK) begin
                dout_d  = R_WIDTH'(rd_word[r_slot*MINW +: MINW]);
                r_sub_d = r_last ? '0 : r_sub_q + 1'b1;
            end else begin
                dout_d  = R_WIDTH'(rd_word);
            end
        end

        w_ptr_d = w_ptr_q;
        if (ent_we) begin
            w_ptr_d = (w_ptr_q == PW'(DEPTH - 1)) ? '0 : w_ptr_q + 1'b1;
        end
        r_ptr_d = r_ptr_q;
        if (ent_fr) begin
            r_ptr_d = (r_ptr_q == PW'(DEPTH - 1)) ? '0 : r_ptr_q + 1'b1;
        end

        cnt_d = cnt_q;
        if (ent_we && !ent_fr) begin
            cnt_d = cnt_q + 1'b1;
        end else if (ent_fr && !ent_we) begin
            cnt_d = cnt_q - 1'b1;
        end

        overflow_d  = overflow_q  | (bus.wr_en & wfull);
        underflow_d = underflow_q | (bus.rd_en & rempty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            w_sub_q     <= '0;
            r_sub_q     <= '0;
            pack_q      <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            w_sub_q     <= w_sub_d;
            r_sub_q     <= r_sub_d;
            pack_q      <= pack_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && ent_we) begin
            mem_q[w_ptr_q] <= wr_word;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.wfull        = wfull;
    assign bus.rempty       = rempty;
    assign bus.almost_full  = (int'(cnt_q) >= AF_LEVEL);
    assign bus.almost_empty = (int'(cnt_q) <= AE_LEVEL);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.fifo_cnt     = cnt_q;
endmodule
